// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the system control coprocessor.
//   - CP0 register numbers used by mfc0/mtc0 (A1/A2)
//   - Synchronous exception codes carried on ExcCode
//   - Bit positions of the SR and Cause fields
//   - The constant processor ID returned for register 15
package cp0_pkg;

  // Register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR field positions
  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  // Cause field positions
  localparam int BD_BIT = 31;
  localparam int IP_HI  = 15;
  localparam int IP_LO  = 10;
  localparam int EXC_HI = 6;
  localparam int EXC_LO = 2;

  localparam logic [31:0] PRID_VALUE = 32'h0019_0305;

endpackage

// File: rtl/cp0.sv
// cp0: system control coprocessor (SR, Cause, EPC, PRId, optional BadVAddr).
// Collects the six hardware interrupt lines and the pipeline's synchronous
// exception code, raises IntReq and records the return state for the handler.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  synchronous, active-low reset
//   A1       in   5  read register number (mfc0)
//   A2       in   5  write register number (mtc0)
//   DIn      in  32  write data (mtc0)
//   We       in   1  write enable for register A2
//   PC       in  32  memory-stage instruction address
//   BD       in   1  memory-stage instruction sits in a branch delay slot
//   ExcCode  in   5  synchronous exception code, 0 = none
//   BadAddr  in  32  faulting address for AdEL/AdES (BadVAddr build only)
//   HWInt    in   6  interrupt lines [7:2], level-sensitive
//   EXLClr   in   1  eret in memory stage
//   IntReq   out  1  take interrupt/exception this cycle
//   EPC      out 32  current EPC value
//   DOut     out 32  read data for A1
//
// Build option: define CP0_BADVADDR_EN to add BadVAddr (register 8).
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [31:0] BadAddr,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  // EPC
  logic [31:0] r_epc;

  logic        w_int_p;
  logic        w_exc_p;
  logic        w_int_req;
  logic [31:0] w_epc_capture;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_badvaddr;

  assign w_int_p   = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_p   = (ExcCode != EXC_INT) & ~r_exl;
  assign w_int_req = w_int_p | w_exc_p;

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign w_epc_capture = (BD ? (PC - 32'd4) : PC) & 32'hFFFF_FFFC;

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc_code, 2'b0};

`ifdef CP0_BADVADDR_EN
  logic [31:0] r_badvaddr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_badvaddr <= 32'b0;
    end else if (w_int_req && !w_int_p &&
                 (ExcCode == EXC_ADEL || ExcCode == EXC_ADES)) begin
      r_badvaddr <= BadAddr;
    end
  end

  assign w_badvaddr = r_badvaddr;
`else
  // BadAddr has no consumer in this build.
  logic w_unused_badaddr;
  assign w_unused_badaddr = ^BadAddr;
  assign w_badvaddr       = 32'b0;
`endif

  // NOTE: reset is tested first inside the clocked block so it overrides
  // every other input, including an IntReq that is pending this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_im       <= 6'b0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= 6'b0;
      r_exc_code <= 5'b0;
      r_epc      <= 32'b0;
    end else begin
      r_ip <= HWInt;
      if (w_int_req) begin
        // Taking the trap discards any mtc0 in the same cycle.
        r_exl      <= 1'b1;
        r_exc_code <= w_int_p ? EXC_INT : ExcCode;
        r_bd       <= BD;
        r_epc      <= w_epc_capture;
      end else begin
        if (We) begin
          case (A2)
            REG_SR: begin
              r_im  <= DIn[IM_HI:IM_LO];
              r_exl <= DIn[EXL_BIT];
              r_ie  <= DIn[IE_BIT];
            end
            REG_EPC: r_epc <= {DIn[31:2], 2'b00};
            default: ;
          endcase
        end
        // NOTE: the later non-blocking assignment wins, so eret beats an
        // mtc0 SR write on EXL while IM/IE still take DIn.
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is
  // inferred for register numbers the case does not list.
  always_comb begin
    DOut = 32'b0;
    case (A1)
      REG_SR:       DOut = w_sr;
      REG_CAUSE:    DOut = w_cause;
      REG_EPC:      DOut = r_epc;
      REG_PRID:     DOut = PRID_VALUE;
      REG_BADVADDR: DOut = w_badvaddr;
      default:      DOut = 32'b0;
    endcase
  end

  assign IntReq = w_int_req;
  assign EPC    = r_epc;

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: table-driven check of cp0. Each vector is one clock cycle: inputs
// are driven on the falling edge, combinational outputs (IntReq, DOut, EPC)
// are compared 1 ns later, before the rising edge commits the cycle.
// A hand-written sequence then covers reset arriving with IntReq pending.
module tb_cp0;
  import cp0_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [31:0] BadAddr;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  cp0 dut (
    .clk     (clk),
    .reset   (reset),
    .A1      (A1),
    .A2      (A2),
    .DIn     (DIn),
    .We      (We),
    .PC      (PC),
    .BD      (BD),
    .ExcCode (ExcCode),
    .BadAddr (BadAddr),
    .HWInt   (HWInt),
    .EXLClr  (EXLClr),
    .IntReq  (IntReq),
    .EPC     (EPC),
    .DOut    (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CP0_BADVADDR_EN
  localparam logic [31:0] EXP_BV = 32'h0000_3001;
`else
  localparam logic [31:0] EXP_BV = 32'h0000_0000;
`endif

  typedef struct {
    logic [4:0]  a1;
    logic        we;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [5:0]  hwint;
    logic [4:0]  exc;
    logic [31:0] pc;
    logic        bd;
    logic        exlclr;
    logic [31:0] badaddr;
    logic        exp_int;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [4:0] a1, input logic we, input logic [4:0] a2, input logic [31:0] din,
    input logic [5:0] hwint, input logic [4:0] exc, input logic [31:0] pc, input logic bd,
    input logic exlclr, input logic [31:0] badaddr,
    input logic exp_int, input logic [31:0] exp_dout, input logic [31:0] exp_epc);
    vec_t v;
    v.a1 = a1; v.we = we; v.a2 = a2; v.din = din; v.hwint = hwint; v.exc = exc;
    v.pc = pc; v.bd = bd; v.exlclr = exlclr; v.badaddr = badaddr;
    v.exp_int = exp_int; v.exp_dout = exp_dout; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic idle_inputs();
    A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; We = 1'b0; PC = 32'h0; BD = 1'b0;
    ExcCode = 5'd0; BadAddr = 32'h0; HWInt = 6'h0; EXLClr = 1'b0;
  endtask

  initial begin
    //                a1          we a2         din           hw     exc       pc            bd exl badaddr       int dout          epc
    // Reset state
    vecs[0]  = mk(REG_SR,       0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0,         32'h0);
    vecs[1]  = mk(REG_CAUSE,    0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0,         32'h0);
    vecs[2]  = mk(REG_EPC,      0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0,         32'h0);
    vecs[3]  = mk(REG_PRID,     0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0019_0305, 32'h0);
    vecs[4]  = mk(REG_BADVADDR, 0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0,         32'h0);
    // mtc0 SR <- 0x401; read of same register returns old value
    vecs[5]  = mk(REG_SR,       1, REG_SR,    32'h0000_0401,6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0,         32'h0);
    // Interrupt on line 0, zero latency
    vecs[6]  = mk(REG_SR,       0, 5'd0,      32'h0,        6'h01, 5'd0,     32'h0000_3010,0, 0, 32'h0,        1, 32'h0000_0401, 32'h0);
    // EXL set, held HWInt masked
    vecs[7]  = mk(REG_SR,       0, 5'd0,      32'h0,        6'h01, 5'd0,     32'h0000_3014,0, 0, 32'h0,        0, 32'h0000_0403, 32'h0000_3010);
    vecs[8]  = mk(REG_CAUSE,    0, 5'd0,      32'h0,        6'h01, 5'd0,     32'h0000_3018,0, 0, 32'h0,        0, 32'h0000_0400, 32'h0000_3010);
    vecs[9]  = mk(REG_EPC,      0, 5'd0,      32'h0,        6'h01, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0000_3010, 32'h0000_3010);
    // eret, then the still-asserted line fires on the first cycle after
    vecs[10] = mk(REG_SR,       0, 5'd0,      32'h0,        6'h01, 5'd0,     32'h0,        0, 1, 32'h0,        0, 32'h0000_0403, 32'h0000_3010);
    vecs[11] = mk(REG_SR,       0, 5'd0,      32'h0,        6'h01, 5'd0,     32'h0000_3040,0, 0, 32'h0,        1, 32'h0000_0401, 32'h0000_3010);
    vecs[12] = mk(REG_EPC,      0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0000_3040, 32'h0000_3040);
    // eret together with mtc0 SR (EXL bit set in DIn): EXL ends 0
    vecs[13] = mk(REG_SR,       1, REG_SR,    32'h0000_FC03,6'h00, 5'd0,     32'h0,        0, 1, 32'h0,        0, 32'h0000_0403, 32'h0000_3040);
    // Overflow exception in delay slot
    vecs[14] = mk(REG_SR,       0, 5'd0,      32'h0,        6'h00, EXC_OV,   32'h0000_3024,1, 0, 32'h0,        1, 32'h0000_FC01, 32'h0000_3040);
    vecs[15] = mk(REG_CAUSE,    0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h8000_0030, 32'h0000_3020);
    // Cause is read-only to mtc0
    vecs[16] = mk(REG_EPC,      1, REG_CAUSE, 32'hFFFF_FFFF,6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0000_3020, 32'h0000_3020);
    // mtc0 EPC with low bits set
    vecs[17] = mk(REG_CAUSE,    1, REG_EPC,   32'h0000_5557,6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h8000_0030, 32'h0000_3020);
    vecs[18] = mk(REG_EPC,      1, REG_SR,    32'h0000_0401,6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0000_5554, 32'h0000_5554);
    // Interrupt beats RI; same-cycle mtc0 EPC discarded
    vecs[19] = mk(REG_SR,       1, REG_EPC,   32'h0000_1234,6'h01, EXC_RI,   32'h0000_3050,0, 0, 32'h0,        1, 32'h0000_0401, 32'h0000_5554);
    vecs[20] = mk(REG_CAUSE,    0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0000_0400, 32'h0000_3050);
    // SR unimplemented bits ignore writes
    vecs[21] = mk(REG_EPC,      1, REG_SR,    32'hFFFF_FFFF,6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0000_3050, 32'h0000_3050);
    vecs[22] = mk(REG_SR,       1, REG_SR,    32'h0000_FC01,6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0000_FC03, 32'h0000_3050);
    // AdEL loads BadVAddr (when built with it)
    vecs[23] = mk(REG_SR,       0, 5'd0,      32'h0,        6'h00, EXC_ADEL, 32'h0000_3060,0, 0, 32'h0000_3001,1, 32'h0000_FC01, 32'h0000_3050);
    vecs[24] = mk(REG_BADVADDR, 0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, EXP_BV,        32'h0000_3060);
    vecs[25] = mk(REG_CAUSE,    0, 5'd0,      32'h0,        6'h00, 5'd0,     32'h0,        0, 0, 32'h0,        0, 32'h0000_0010, 32'h0000_3060);

    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      A1 = vecs[i].a1; We = vecs[i].we; A2 = vecs[i].a2; DIn = vecs[i].din;
      HWInt = vecs[i].hwint; ExcCode = vecs[i].exc; PC = vecs[i].pc; BD = vecs[i].bd;
      EXLClr = vecs[i].exlclr; BadAddr = vecs[i].badaddr;
      #1;
      check($sformatf("v%0d IntReq", i), {31'b0, IntReq}, {31'b0, vecs[i].exp_int});
      check($sformatf("v%0d DOut", i), DOut, vecs[i].exp_dout);
      check($sformatf("v%0d EPC", i), EPC, vecs[i].exp_epc);
    end

    // Reset arriving while an IntReq is pending and an mtc0 is issued.
    @(negedge clk);
    idle_inputs();
    EXLClr = 1'b1;                // EXL was left set by vector 23
    @(negedge clk);
    idle_inputs();
    HWInt   = 6'h3F;
    ExcCode = EXC_ADES;
    BadAddr = 32'hDEAD_BEEC;
    PC      = 32'h0000_4000;
    We = 1'b1; A2 = REG_EPC; DIn = 32'h0000_ABCD;
    reset   = 1'b0;
    #1;
    check("pending IntReq before reset", {31'b0, IntReq}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    We    = 1'b0;
    ExcCode = 5'd0;
    #1;
    check("IntReq after reset", {31'b0, IntReq}, 32'd0);
    check("EPC after reset", EPC, 32'h0);
    A1 = REG_SR;       #1; check("SR after reset", DOut, 32'h0);
    A1 = REG_CAUSE;    #1; check("Cause after reset", DOut, 32'h0);
    A1 = REG_EPC;      #1; check("EPC reg after reset", DOut, 32'h0);
    A1 = REG_BADVADDR; #1; check("BadVAddr after reset", DOut, 32'h0);
    A1 = REG_PRID;     #1; check("PRId after reset", DOut, 32'h0019_0305);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
